// File: rtl/ifetch.sv
// Instruction fetch: issues one memory read at a time and buffers returned words
// with their PCs in a small circular queue feeding decode; flush redirects fetch.
module ifetch #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_inst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic [1:0]  dbg_state_o
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
   localparam logic [AW-1:0] ONE_A   = AW'(1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   mem_addr_q;
   logic          mem_req_q;
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [31:0]   inst_mem_q [QUEUE_DEPTH];
   logic [31:0]   pc_mem_q   [QUEUE_DEPTH];

   logic          do_push;
   logic          do_pop;
   logic [31:0]   flush_pc_al;

   always_comb begin
      do_pop      = (count_q != '0) && out_ready && !flush;
      do_push     = (state_q == BUSY) && mem_done && !flush;
      flush_pc_al = flush_pc & ~32'h3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else if (rdy) begin
         if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= flush_pc_al;
            mem_req_q  <= 1'b0;
            // A response still owed by memory must be swallowed in DROP; once it
            // arrives (even alongside a flush) nothing is outstanding, so go IDLE.
            case (state_q)
               BUSY:    state_q <= mem_done ? IDLE : DROP;
               DROP:    state_q <= mem_done ? IDLE : DROP;
               default: state_q <= IDLE;
            endcase
         end else begin
            if (do_push) begin
               inst_mem_q[tail_q] <= mem_inst;
               pc_mem_q[tail_q]   <= fetch_pc_q;
               tail_q             <= tail_q + ONE_A;
            end
            if (do_pop) begin
               head_q <= head_q + ONE_A;
            end
            case ({do_push, do_pop})
               2'b10:   count_q <= count_q + ONE_C;
               2'b01:   count_q <= count_q - ONE_C;
               default: ;
            endcase

            // Requests only start with a free slot, so a push never finds the queue full.
            case (state_q)
               IDLE: begin
                  if (count_q < DEPTH_C) begin
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= fetch_pc_q;
                     state_q    <= BUSY;
                  end
               end
               BUSY: begin
                  if (mem_done) begin
                     fetch_pc_q <= fetch_pc_q + 32'd4;
                     mem_req_q  <= 1'b0;
                     state_q    <= IDLE;
                  end
               end
               DROP: begin
                  if (mem_done) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign out_valid   = (count_q != '0);
   assign out_inst    = inst_mem_q[head_q];
   assign out_pc      = pc_mem_q[head_q];
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: streaming, queue-full backpressure, flush cases,
// simultaneous push/pop and rdy stall, each in its own scenario task.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_inst;
   logic        flush;
   logic [31:0] flush_pc;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   ifetch dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_done   (mem_done),
      .mem_inst   (mem_inst),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .out_valid  (out_valid),
      .out_inst   (out_inst),
      .out_pc     (out_pc),
      .out_ready  (out_ready),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
      mem_done = 1'b0; mem_inst = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Memory driver: wait for a request, hold it for 'delay' cycles, then answer.
   task automatic serve(input int delay, input logic [31:0] data,
                        output logic [31:0] addr, output bit ok, output bit stable);
      stable = 1'b1;
      addr   = 'x;
      wait_req(ok);
      if (!ok) return;
      addr = mem_addr;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b1 || mem_addr !== addr) stable = 1'b0;
      end
      mem_done = 1'b1; mem_inst = data;
      @(negedge clk);
      mem_done = 1'b0; mem_inst = '0;
   endtask

   task automatic test_reset();
      bit ok;
      apply_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1; rdy = 1'b0; flush = 1'b1; flush_pc = 32'h40;
      @(negedge clk);
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      wait_req(ok);
      n_checks++; if (!ok || mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_addr: got %h ok=%0d want 00000000", mem_addr, ok); end
   endtask

   task automatic test_stream();
      logic [31:0] a;
      bit ok, st;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         serve(2, inst_of(32'(i * 4)), a, ok, st);
         n_checks++; if (!ok || a !== 32'(i * 4) || !st) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h ok=%0d stable=%0d want %h", i, a, ok, st, 32'(i * 4)); end
         n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== inst_of(32'(i * 4))) begin
            n_fail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, out_valid, out_pc, out_inst, 32'(i * 4), inst_of(32'(i * 4)));
         end
      end
   endtask

   task automatic test_full();
      logic [31:0] a;
      bit ok, st, quiet;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         serve(1, inst_of(32'(i * 4)), a, ok, st);
         n_checks++; if (!ok || a !== 32'(i * 4)) begin n_fail++; $display("FAIL full_addr[%0d]: got %h ok=%0d want %h", i, a, ok, 32'(i * 4)); end
      end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b0) quiet = 1'b0;
      end
      n_checks++; if (!quiet) begin n_fail++; $display("FAIL full_no_req: got mem_req=1 while full want 0"); end
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(j * 4) || out_inst !== inst_of(32'(j * 4))) begin
            n_fail++; $display("FAIL full_drain[%0d]: got v=%b pc=%h inst=%h want pc=%h", j, out_valid, out_pc, out_inst, 32'(j * 4));
         end
         @(negedge clk);
      end
      serve(1, inst_of(32'h10), a, ok, st);
      n_checks++; if (!ok || a !== 32'h10) begin n_fail++; $display("FAIL full_resume: got %h ok=%0d want 00000010", a, ok); end
   endtask

   task automatic test_flush_busy();
      logic [31:0] a;
      bit ok, st;
      apply_reset();
      out_ready = 1'b1;
      serve(1, inst_of(32'h0), a, ok, st);
      serve(1, inst_of(32'h4), a, ok, st);
      wait_req(ok);
      n_checks++; if (!ok || mem_addr !== 32'h8) begin n_fail++; $display("FAIL fbusy_addr: got %h ok=%0d want 00000008", mem_addr, ok); end
      flush = 1'b1; flush_pc = 32'h100;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (mem_req !== 1'b0 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL fbusy_drop: got req=%b state=%0d want req=0 state=2", mem_req, dbg_state); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fbusy_drop_req: got %b want 0", mem_req); end
      mem_done = 1'b1; mem_inst = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_done = 1'b0; mem_inst = '0;
      n_checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL fbusy_discard: got v=%b state=%0d want v=0 state=0", out_valid, dbg_state); end
      serve(1, inst_of(32'h100), a, ok, st);
      n_checks++; if (!ok || a !== 32'h100) begin n_fail++; $display("FAIL fbusy_next_addr: got %h ok=%0d want 00000100", a, ok); end
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== inst_of(32'h100)) begin
         n_fail++; $display("FAIL fbusy_next_out: got v=%b pc=%h inst=%h want pc=00000100", out_valid, out_pc, out_inst);
      end
   endtask

   task automatic test_flush_done();
      logic [31:0] a;
      bit ok, st;
      apply_reset();
      serve(1, inst_of(32'h0), a, ok, st);
      serve(1, inst_of(32'h4), a, ok, st);
      wait_req(ok);
      n_checks++; if (!ok || mem_addr !== 32'h8) begin n_fail++; $display("FAIL fdone_addr: got %h ok=%0d want 00000008", mem_addr, ok); end
      mem_done = 1'b1; mem_inst = 32'h1234_5678; flush = 1'b1; flush_pc = 32'h200;
      @(negedge clk);
      mem_done = 1'b0; mem_inst = '0; flush = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL fdone_state: got v=%b req=%b state=%0d want 0 0 0", out_valid, mem_req, dbg_state);
      end
      serve(1, inst_of(32'h200), a, ok, st);
      n_checks++; if (!ok || a !== 32'h200) begin n_fail++; $display("FAIL fdone_next_addr: got %h ok=%0d want 00000200", a, ok); end
      // Now IDLE with one entry queued: flush with a misaligned target.
      flush = 1'b1; flush_pc = 32'h303;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (dbg_state !== 2'd0 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL fidle_state: got state=%0d req=%b v=%b want 0 0 0", dbg_state, mem_req, out_valid);
      end
      serve(1, inst_of(32'h300), a, ok, st);
      n_checks++; if (!ok || a !== 32'h300) begin n_fail++; $display("FAIL fidle_align: got %h ok=%0d want 00000300", a, ok); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      bit ok, st;
      apply_reset();
      for (int i = 0; i < 3; i++) serve(1, inst_of(32'(i * 4)), a, ok, st);
      wait_req(ok);
      n_checks++; if (!ok || mem_addr !== 32'hC) begin n_fail++; $display("FAIL b2b_addr: got %h ok=%0d want 0000000c", mem_addr, ok); end
      @(negedge clk);
      out_ready = 1'b1; mem_done = 1'b1; mem_inst = inst_of(32'hC);
      @(negedge clk);
      mem_done = 1'b0; mem_inst = '0;
      for (int j = 0; j < 3; j++) begin
         n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 + j * 4) || out_inst !== inst_of(32'(4 + j * 4))) begin
            n_fail++; $display("FAIL b2b_order[%0d]: got v=%b pc=%h inst=%h want pc=%h", j, out_valid, out_pc, out_inst, 32'(4 + j * 4));
         end
         @(negedge clk);
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_count: got out_valid=%b after 3 pops want 0", out_valid); end
   endtask

   task automatic test_stall();
      logic [31:0] a;
      bit ok, st, held;
      apply_reset();
      serve(1, inst_of(32'h0), a, ok, st);
      wait_req(ok);
      n_checks++; if (!ok || mem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_addr: got %h ok=%0d want 00000004", mem_addr, ok); end
      rdy = 1'b0; out_ready = 1'b1;
      held = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         mem_done = (k == 1);
         mem_inst = (k == 1) ? 32'hBAD0_BAD0 : 32'h0;
         if (mem_req !== 1'b1 || mem_addr !== 32'h4 || out_valid !== 1'b1 || out_pc !== 32'h0 || dbg_state !== 2'd1) held = 1'b0;
      end
      rdy = 1'b1; out_ready = 1'b0; mem_done = 1'b0; mem_inst = '0;
      n_checks++; if (!held) begin n_fail++; $display("FAIL stall_hold: state changed while rdy=0 want hold"); end
      @(negedge clk);
      n_checks++; if (dbg_state !== 2'd1 || mem_req !== 1'b1 || out_pc !== 32'h0) begin
         n_fail++; $display("FAIL stall_resume: got state=%0d req=%b pc=%h want 1 1 00000000", dbg_state, mem_req, out_pc);
      end
      mem_done = 1'b1; mem_inst = inst_of(32'h4);
      @(negedge clk);
      mem_done = 1'b0; mem_inst = '0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== inst_of(32'h4)) begin
         n_fail++; $display("FAIL stall_push: got v=%b pc=%h inst=%h want pc=00000004", out_valid, out_pc, out_inst);
      end
      serve(1, inst_of(32'h8), a, ok, st);
      n_checks++; if (!ok || a !== 32'h8) begin n_fail++; $display("FAIL stall_next_addr: got %h ok=%0d want 00000008", a, ok); end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;
      mem_done = 1'b0; mem_inst = '0; out_ready = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_flush_busy();
      test_flush_done();
      test_back_to_back();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
